// File: rtl/output_sequencer.sv
// output_sequencer: steers MAC1/MAC2 results into the output register bank
// and then streams the 16 symmetric-matrix entries out in row-major order
// under a ready handshake.
module output_sequencer #(
    parameter int NUM_RES = 5,
    parameter int NUM_OUT = 16
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       start,
    input  logic       mac1_valid,
    input  logic       mac2_valid,
    input  logic       dout_ready,
    output logic       mac_start,
    output logic [2:0] input_sel1,
    output logic [2:0] input_sel2,
    output logic       output_rdy,
    output logic [3:0] reg_out_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] RES_N    = 3'(NUM_RES);
    localparam logic [3:0] OUT_LAST = 4'(NUM_OUT - 1);
    localparam logic [2:0] NO_LOAD  = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt1;
    logic [2:0] cnt1_nxt;
    logic [2:0] cnt2;
    logic [2:0] cnt2_nxt;
    logic [3:0] ocnt;
    logic [3:0] ocnt_nxt;
    logic       err_nxt;
    logic       done_nxt;

    // State register; aclr drops the controller straight back to IDLE.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result counters, drain index and the sticky/pulse status flags.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt1 <= 3'd0;
            cnt2 <= 3'd0;
            ocnt <= 4'd0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            cnt1 <= cnt1_nxt;
            cnt2 <= cnt2_nxt;
            ocnt <= ocnt_nxt;
            err  <= err_nxt;
            done <= done_nxt;
        end
    end

    // Next-state, counter updates and combinational select outputs.
    always_comb begin
        state_nxt   = state;
        cnt1_nxt    = cnt1;
        cnt2_nxt    = cnt2;
        ocnt_nxt    = ocnt;
        err_nxt     = err;
        done_nxt    = 1'b0;
        mac_start   = 1'b0;
        input_sel1  = NO_LOAD;
        input_sel2  = NO_LOAD;
        output_rdy  = 1'b0;
        reg_out_sel = 4'd0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                // A stray result with no job running is flagged, but a new
                // job request clears the flag.
                if (mac1_valid || mac2_valid) begin
                    err_nxt = 1'b1;
                end
                if (start) begin
                    cnt1_nxt  = 3'd0;
                    cnt2_nxt  = 3'd0;
                    ocnt_nxt  = 4'd0;
                    err_nxt   = 1'b0;
                    state_nxt = LAUNCH;
                end
            end

            LAUNCH: begin
                mac_start = 1'b1;
                if (mac1_valid || mac2_valid) begin
                    err_nxt = 1'b1;
                end
                state_nxt = CAPTURE;
            end

            CAPTURE: begin
                // Slot index is the registered count, so the select is
                // valid in the same cycle as the MAC result.
                if (mac1_valid) begin
                    if (cnt1 < RES_N) begin
                        input_sel1 = cnt1;
                        cnt1_nxt   = cnt1 + 3'd1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                if (mac2_valid) begin
                    if (cnt2 < RES_N) begin
                        input_sel2 = cnt2;
                        cnt2_nxt   = cnt2 + 3'd1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                // The last result is written at this same edge, so the bank
                // is complete by the first drain cycle.
                if ((cnt1_nxt == RES_N) && (cnt2_nxt == RES_N)) begin
                    state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                output_rdy  = 1'b1;
                reg_out_sel = ocnt;
                if (mac1_valid || mac2_valid) begin
                    err_nxt = 1'b1;
                end
                // Without ready the same entry is simply re-latched.
                if (dout_ready) begin
                    if (ocnt == OUT_LAST) begin
                        ocnt_nxt  = 4'd0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ocnt_nxt = ocnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_output_sequencer.sv
// Testbench for output_sequencer: randomized job stimulus with a
// transaction-level expectation of select, drain and status behaviour.
module tb_output_sequencer;

    localparam int NUM_RES = 5;
    localparam int NUM_OUT = 16;
    localparam logic [2:0] NL = 3'b111;

    logic       clk = 1'b0;
    logic       aclr;
    logic       start;
    logic       mac1_valid;
    logic       mac2_valid;
    logic       dout_ready;
    logic       mac_start;
    logic [2:0] input_sel1;
    logic [2:0] input_sel2;
    logic       output_rdy;
    logic [3:0] reg_out_sel;
    logic       busy;
    logic       done;
    logic       err;

    int   total = 0;
    int   bad   = 0;
    logic exp_err;

    always #5 clk = ~clk;

    output_sequencer #(
        .NUM_RES(NUM_RES),
        .NUM_OUT(NUM_OUT)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .start      (start),
        .mac1_valid (mac1_valid),
        .mac2_valid (mac2_valid),
        .dout_ready (dout_ready),
        .mac_start  (mac_start),
        .input_sel1 (input_sel1),
        .input_sel2 (input_sel2),
        .output_rdy (output_rdy),
        .reg_out_sel(reg_out_sel),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: moves to the mid-cycle sample point.
    task automatic settle();
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ms, input logic [2:0] s1,
                              input logic [2:0] s2, input logic rdy, input logic [3:0] sel,
                              input logic bsy, input logic dn);
        check({tag, "_mac_start"},  8'(mac_start),   8'(ms));
        check({tag, "_sel1"},       8'(input_sel1),  8'(s1));
        check({tag, "_sel2"},       8'(input_sel2),  8'(s2));
        check({tag, "_output_rdy"}, 8'(output_rdy),  8'(rdy));
        check({tag, "_reg_out_sel"},8'(reg_out_sel), 8'(sel));
        check({tag, "_busy"},       8'(busy),        8'(bsy));
        check({tag, "_done"},       8'(done),        8'(dn));
        check({tag, "_err"},        8'(err),         8'(exp_err));
    endtask

    // mode 0: mac1 results then mac2 results on separate cycles
    // mode 1: both MACs coincident on every cycle
    // mode 2: random valids and random dout_ready
    task automatic run_job(input int mode, input bit excess, input bit stall,
                           input int aclr_at, input bit stray);
        int  n1, n2, cyc, e, dcyc, stall_left;
        bit  v1, v2, rdy, xtra_done;
        logic [2:0] e1, e2;

        // IDLE with start
        start = 1'b1;
        settle();
        check_outs("idle", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b0);
        next_cycle();
        exp_err = 1'b0;

        // LAUNCH; a repeated start here must be ignored
        start = 1'b1;
        settle();
        check_outs("launch", 1'b1, NL, NL, 1'b0, 4'd0, 1'b1, 1'b0);
        next_cycle();

        // CAPTURE
        n1 = 0; n2 = 0; cyc = 0; xtra_done = !excess;
        while (n1 < NUM_RES || n2 < NUM_RES) begin
            start = (cyc == 0);
            if (mode == 0) begin
                if (n1 < NUM_RES) begin v1 = 1; v2 = 0; end
                else if (!xtra_done) begin v1 = 1; v2 = 0; xtra_done = 1; end
                else begin v1 = 0; v2 = 1; end
            end else if (mode == 1) begin
                v1 = 1; v2 = 1;
            end else if (cyc > 40) begin
                v1 = (n1 < NUM_RES); v2 = (n2 < NUM_RES);
            end else begin
                v1 = ((n1 < NUM_RES) || excess) ? 1'($urandom_range(0, 1)) : 1'b0;
                v2 = (n2 < NUM_RES) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            mac1_valid = v1;
            mac2_valid = v2;
            e1 = (v1 && n1 < NUM_RES) ? 3'(n1) : NL;
            e2 = (v2 && n2 < NUM_RES) ? 3'(n2) : NL;
            settle();
            check_outs("cap", 1'b0, e1, e2, 1'b0, 4'd0, 1'b1, 1'b0);
            if (v1) begin if (n1 < NUM_RES) n1++; else exp_err = 1'b1; end
            if (v2) begin if (n2 < NUM_RES) n2++; else exp_err = 1'b1; end
            next_cycle();
            cyc++;
        end
        start = 1'b0;
        mac1_valid = 1'b0;
        mac2_valid = 1'b0;

        // DRAIN: one entry index per accepted transfer
        e = 0; dcyc = 0; stall_left = stall ? 3 : 0;
        while (e < NUM_OUT) begin
            if (stall && e == 7 && stall_left > 0) begin
                rdy = 0; stall_left--;
            end else if (mode == 2) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1;
            end
            dout_ready = rdy;
            mac2_valid = (stray && dcyc == 2);
            if (aclr_at >= 0 && e == aclr_at) begin
                #2;
                aclr = 1'b1;
                #1;
                exp_err = 1'b0;
                check_outs("aclr_now", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b0);
                dout_ready = 1'b0;
                mac2_valid = 1'b0;
                next_cycle();
                settle();
                check_outs("aclr_held", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b0);
                aclr = 1'b0;
                next_cycle();
                settle();
                check_outs("aclr_after", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b0);
                next_cycle();
                return;
            end
            settle();
            check_outs("drain", 1'b0, NL, NL, 1'b1, 4'(e), 1'b1, 1'b0);
            if (stray && dcyc == 2) exp_err = 1'b1;
            if (rdy) e++;
            next_cycle();
            dcyc++;
        end
        dout_ready = 1'b0;
        mac2_valid = 1'b0;

        // done pulse with busy already low, then quiet
        settle();
        check_outs("done", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b1);
        next_cycle();
        settle();
        check_outs("post", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b0);
        next_cycle();
    endtask

    initial begin
        aclr       = 1'b1;
        start      = 1'b0;
        mac1_valid = 1'b0;
        mac2_valid = 1'b0;
        dout_ready = 1'b0;
        exp_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        settle();
        check_outs("reset", 1'b0, NL, NL, 1'b0, 4'd0, 1'b0, 1'b0);
        aclr = 1'b0;
        next_cycle();

        run_job(0, 1'b0, 1'b0, -1, 1'b0);   // separate valids
        run_job(1, 1'b0, 1'b0, -1, 1'b0);   // coincident valids
        run_job(0, 1'b1, 1'b1, -1, 1'b0);   // excess mac1 valid + ready stall at 7
        run_job(2, 1'b0, 1'b0, -1, 1'b1);   // stray valid during drain
        run_job(0, 1'b0, 1'b0, 5, 1'b0);    // aclr at ocnt = 5
        run_job(0, 1'b0, 1'b0, -1, 1'b0);   // full job after aclr
        for (int j = 0; j < 8; j++) begin
            run_job(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
